// File: rtl/spi_link_pkg.sv
// Shared constants and FSM state type for the SPI link transmitter.
package spi_link_pkg;

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned BIT_CNT_W = 5;
   localparam int unsigned GAP_CNT_W = 4;
   localparam int unsigned DIV_CNT_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_e;

endpackage

// File: rtl/spi_link_clkgen.sv
// Link clock divider: free-running TX_CLK and a strobe marking the cycle whose edge drops TX_CLK.
module spi_link_clkgen
   import spi_link_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tx_clk_o,
   output logic bit_stb_o
);

   localparam logic [DIV_CNT_W-1:0] DivMax = DIV_CNT_W'(CLK_DIV - 1);

   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic                 clk_q, clk_d;
   logic                 wrap;

   assign wrap = (cnt_q == DivMax);

   always_comb begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      clk_d = wrap ? ~clk_q : clk_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         clk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         clk_q <= clk_d;
      end
   end

   assign tx_clk_o  = clk_q;
   // Line registers update on the same edge that drops TX_CLK.
   assign bit_stb_o = wrap & clk_q;

endmodule

// File: rtl/spi_link_tx.sv
// Transmit end of the four-wire SPI link: holding register, shift FSM, LOAD/STOP framing and
// per-message word counter.
module spi_link_tx
   import spi_link_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned GAP_BITS = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] WORD_DATA,
   input  logic              WORD_VALID,
   input  logic              WORD_LAST,
   output logic              WORD_READY,
   output logic              TX_CLK,
   output logic              TX_DATA,
   output logic              TX_LOAD,
   output logic              TX_STOP,
   output logic              BUSY,
   output logic [7:0]        MSG_WORDS
);

   localparam logic [GAP_CNT_W-1:0] GapLast = GAP_CNT_W'(GAP_BITS);
   localparam logic [BIT_CNT_W-1:0] LastBit = BIT_CNT_W'(WORD_W);

   state_e               state_q, state_d;
   logic [WORD_W-1:0]    hold_q, hold_d;
   logic                 hold_last_q, hold_last_d;
   logic                 hold_full_q, hold_full_d;
   logic [WORD_W-1:0]    shift_q, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic                 data_q, data_d;
   logic                 load_q, load_d;
   logic                 stop_q, stop_d;
   logic [7:0]           word_cnt_q, word_cnt_d;
   logic [7:0]           msg_q, msg_d;
   logic                 rdy_en_q;

   logic                 bit_stb;
   logic                 accept;
   logic                 take;
   logic                 done;
   logic [7:0]           sat_cnt;

   spi_link_clkgen #(
      .CLK_DIV(CLK_DIV)
   ) u_clkgen (
      .clk_i    (CLK),
      .rst_ni   (RST),
      .tx_clk_o (TX_CLK),
      .bit_stb_o(bit_stb)
   );

   assign WORD_READY = rdy_en_q & ~hold_full_q;
   assign accept     = WORD_VALID & WORD_READY;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_last_d = hold_last_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      data_d      = data_q;
      load_d      = load_q;
      stop_d      = stop_q;
      word_cnt_d  = word_cnt_q;
      msg_d       = msg_q;
      take        = 1'b0;
      done        = 1'b0;
      sat_cnt     = (word_cnt_q == 8'hFF) ? 8'hFF : word_cnt_q + 8'd1;

      if (bit_stb) begin
         case (state_q)
            StIdle: begin
               if (hold_full_q) take = 1'b1;
            end
            StShift: begin
               if (bit_cnt_q == LastBit) begin
                  done = 1'b1;
                  if (GAP_BITS > 0) begin
                     state_d   = StGap;
                     gap_cnt_d = GAP_CNT_W'(1);
                     data_d    = 1'b0;
                     load_d    = 1'b0;
                     stop_d    = 1'b0;
                  end else if (hold_full_q) begin
                     take = 1'b1;
                  end else begin
                     state_d = StIdle;
                     data_d  = 1'b0;
                     load_d  = 1'b0;
                     stop_d  = 1'b0;
                  end
               end else begin
                  shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                  data_d    = shift_q[WORD_W-2];
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            StGap: begin
               if (gap_cnt_q == GapLast) begin
                  if (hold_full_q) take = 1'b1;
                  else             state_d = StIdle;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (take) begin
         state_d     = StShift;
         shift_d     = hold_q;
         data_d      = hold_q[WORD_W-1];
         load_d      = 1'b1;
         stop_d      = hold_last_q;
         bit_cnt_d   = BIT_CNT_W'(1);
         hold_full_d = 1'b0;
      end

      // stop_q still carries the finishing word's LAST flag on its final boundary.
      if (done) begin
         if (stop_q) begin
            msg_d      = sat_cnt;
            word_cnt_d = '0;
         end else begin
            word_cnt_d = sat_cnt;
         end
      end

      if (accept) begin
         hold_d      = WORD_DATA;
         hold_last_d = WORD_LAST;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         hold_last_q <= 1'b0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         data_q      <= 1'b0;
         load_q      <= 1'b0;
         stop_q      <= 1'b0;
         word_cnt_q  <= '0;
         msg_q       <= '0;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_last_q <= hold_last_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         data_q      <= data_d;
         load_q      <= load_d;
         stop_q      <= stop_d;
         word_cnt_q  <= word_cnt_d;
         msg_q       <= msg_d;
         rdy_en_q    <= 1'b1;
      end
   end

   assign TX_DATA   = data_q;
   assign TX_LOAD   = load_q;
   assign TX_STOP   = stop_q;
   assign BUSY      = (state_q != StIdle) | hold_full_q;
   assign MSG_WORDS = msg_q;

endmodule

// File: tb/tb_spi_link_tx.sv
// Bench for spi_link_tx: three instances (GAP_BITS 1/0/2) with line monitors and a scoreboard.
module tb_spi_link_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] wd [3];
   logic        wv [3];
   logic        wl [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : mon
      logic       tx_clk, tx_data, tx_load, tx_stop, ready, busy;
      logic [7:0] msg;

      spi_link_tx #(
         .CLK_DIV (4),
         .GAP_BITS((g == 0) ? 1 : ((g == 1) ? 0 : 2))
      ) u_dut (
         .CLK       (clk),
         .RST       (rst),
         .WORD_DATA (wd[g]),
         .WORD_VALID(wv[g]),
         .WORD_LAST (wl[g]),
         .WORD_READY(ready),
         .TX_CLK    (tx_clk),
         .TX_DATA   (tx_data),
         .TX_LOAD   (tx_load),
         .TX_STOP   (tx_stop),
         .BUSY      (busy),
         .MSG_WORDS (msg)
      );

      // Receiver model: sample on TX_CLK rise; record {gap, stop_or, stop_and, data} per word.
      logic        prev_clk = 1'b0;
      int          bitcnt   = 0;
      int          run      = 0;
      logic [7:0]  gapcnt   = 8'd0;
      logic [7:0]  cur_gap  = 8'd0;
      logic [15:0] sh       = 16'd0;
      logic        s_or     = 1'b0;
      logic        s_and    = 1'b1;
      logic [25:0] rxw [$];
      int          runs [$];

      always @(negedge clk) begin
         prev_clk <= tx_clk;
         if (tx_clk === 1'b1 && prev_clk === 1'b0) begin
            if (tx_load === 1'b1) begin
               if (bitcnt == 0) begin
                  cur_gap <= gapcnt;
                  s_or    <= tx_stop;
                  s_and   <= tx_stop;
               end else begin
                  s_or    <= s_or | tx_stop;
                  s_and   <= s_and & tx_stop;
               end
               sh     <= {sh[14:0], tx_data};
               run    <= run + 1;
               gapcnt <= 8'd0;
               if (bitcnt == 15) begin
                  rxw.push_back({cur_gap, s_or | tx_stop, s_and & tx_stop, sh[14:0], tx_data});
                  bitcnt <= 0;
               end else begin
                  bitcnt <= bitcnt + 1;
               end
            end else begin
               bitcnt <= 0;
               if (gapcnt < 8'd255) gapcnt <= gapcnt + 8'd1;
               if (run > 0) runs.push_back(run);
               run <= 0;
            end
         end
      end
   end

   typedef struct packed {
      logic [1:0]  g;
      logic        chk_gap;
      logic [7:0]  gap;
      logic        last;
      logic [15:0] data;
   } exp_t;

   exp_t expq [$];
   int   rd_idx [3];
   int   n_pass   = 0;
   int   n_chk    = 0;
   int   timeouts = 0;

   function automatic int rx_size(input int g);
      case (g)
         0:       rx_size = mon[0].rxw.size();
         1:       rx_size = mon[1].rxw.size();
         default: rx_size = mon[2].rxw.size();
      endcase
   endfunction

   function automatic logic [25:0] rx_word(input int g, input int i);
      case (g)
         0:       rx_word = mon[0].rxw[i];
         1:       rx_word = mon[1].rxw[i];
         default: rx_word = mon[2].rxw[i];
      endcase
   endfunction

   function automatic logic rdy(input int g);
      case (g)
         0:       rdy = mon[0].ready;
         1:       rdy = mon[1].ready;
         default: rdy = mon[2].ready;
      endcase
   endfunction

   function automatic logic [7:0] msg_of(input int g);
      case (g)
         0:       msg_of = mon[0].msg;
         1:       msg_of = mon[1].msg;
         default: msg_of = mon[2].msg;
      endcase
   endfunction

   function automatic int last_run(input int g);
      case (g)
         0:       last_run = (mon[0].runs.size() > 0) ? mon[0].runs[mon[0].runs.size()-1] : -1;
         1:       last_run = (mon[1].runs.size() > 0) ? mon[1].runs[mon[1].runs.size()-1] : -1;
         default: last_run = (mon[2].runs.size() > 0) ? mon[2].runs[mon[2].runs.size()-1] : -1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called at a negedge; returns at a negedge after the word has been accepted.
   task automatic send(input int g, input logic [15:0] d, input logic l, input logic push,
                       input logic chk_gap, input logic [7:0] gap, output int waits);
      exp_t e;
      waits = 0;
      wd[g] = d;
      wl[g] = l;
      wv[g] = 1'b1;
      while (rdy(g) !== 1'b1 && waits < 4000) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 4000) timeouts++;
      @(negedge clk);
      wv[g] = 1'b0;
      if (push) begin
         e.g       = 2'(g);
         e.chk_gap = chk_gap;
         e.gap     = gap;
         e.last    = l;
         e.data    = d;
         expq.push_back(e);
      end
   endtask

   task automatic drain();
      exp_t        e;
      logic [25:0] r;
      int          n;
      int          g;
      while (expq.size() > 0) begin
         e = expq.pop_front();
         g = int'(e.g);
         n = 0;
         while (rx_size(g) <= rd_idx[g] && n < 3000) begin
            @(negedge clk);
            n++;
         end
         check("rx_timeout", 32'(n >= 3000), 32'd0);
         if (n < 3000) begin
            r = rx_word(g, rd_idx[g]);
            rd_idx[g]++;
            check("rx_data", 32'(r[15:0]), 32'(e.data));
            check("rx_stop", 32'(r[17:16]), 32'({e.last, e.last}));
            if (e.chk_gap) check("rx_gap", 32'(r[25:18]), 32'(e.gap));
         end
      end
   endtask

   task automatic wait_bits(input int n);
      repeat (n * 8) @(negedge clk);
   endtask

   initial begin
      int   w;
      int   t0;
      int   t1;
      int   lat;
      logic prev;

      for (int i = 0; i < 3; i++) begin
         wd[i]     = '0;
         wv[i]     = 1'b0;
         wl[i]     = 1'b0;
         rd_idx[i] = 0;
      end

      // Reset held for three edges.
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", 32'({mon[0].tx_clk, mon[0].tx_data, mon[0].tx_load, mon[0].tx_stop,
                                mon[0].ready, mon[0].busy}), 32'd0);
      check("rst_msg", 32'(mon[0].msg), 32'd0);
      check("rst_load_all", 32'({mon[1].tx_load, mon[2].tx_load, mon[1].ready, mon[2].ready}),
            32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(mon[0].ready), 32'd1);
      check("busy_after_rst", 32'(mon[0].busy), 32'd0);

      t0   = -1;
      t1   = -1;
      prev = mon[0].tx_clk;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (prev === 1'b0 && mon[0].tx_clk === 1'b1) begin
            if (t0 < 0)      t0 = i;
            else if (t1 < 0) t1 = i;
         end
         prev = mon[0].tx_clk;
      end
      check("txclk_period", 32'(t1 - t0), 32'd8);

      // Single word, GAP_BITS=1.
      send(0, 16'hA5C3, 1'b1, 1'b1, 1'b0, 8'd0, w);
      lat = 0;
      while (mon[0].tx_load !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("first_bit_latency", 32'(lat <= 8), 32'd1);
      check("busy_while_shift", 32'(mon[0].busy), 32'd1);
      drain();
      wait_bits(4);
      check("single_load_len", 32'(last_run(0)), 32'd16);
      check("single_msg", 32'(msg_of(0)), 32'd1);

      // Back-to-back, GAP_BITS=0.
      send(1, 16'h1234, 1'b0, 1'b1, 1'b0, 8'd0, w);
      send(1, 16'h5678, 1'b1, 1'b1, 1'b1, 8'd0, w);
      drain();
      wait_bits(4);
      check("b2b_load_len", 32'(last_run(1)), 32'd32);
      check("b2b_msg", 32'(msg_of(1)), 32'd2);

      // Backpressure with VALID held, GAP_BITS=2.
      send(2, 16'h0F0F, 1'b0, 1'b1, 1'b0, 8'd0, w);
      send(2, 16'hF00F, 1'b0, 1'b1, 1'b1, 8'd2, w);
      wd[2] = 16'h3C3C;
      wl[2] = 1'b1;
      wv[2] = 1'b1;
      @(negedge clk);
      check("bp_ready_low", 32'({mon[2].ready, mon[2].busy}), 32'b01);
      send(2, 16'h3C3C, 1'b1, 1'b1, 1'b1, 8'd2, w);
      check("bp_stalled", 32'(w > 8), 32'd1);
      drain();
      wait_bits(4);
      check("bp_msg", 32'(msg_of(2)), 32'd3);
      check("bp_idle", 32'({mon[2].busy, mon[2].ready}), 32'b01);

      // Reset in the middle of a word.
      send(0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd0, w);
      lat = 0;
      while (mon[0].bitcnt != 8 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check("midword_reached", 32'(lat < 400), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_line", 32'({mon[0].tx_load, mon[0].tx_data, mon[0].tx_stop, mon[0].busy}),
            32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(mon[0].ready), 32'd1);
      send(0, 16'h8001, 1'b1, 1'b1, 1'b0, 8'd0, w);
      drain();
      wait_bits(4);
      check("midrst_len", 32'(last_run(0)), 32'd16);
      check("midrst_msg", 32'(msg_of(0)), 32'd1);

      // Counter saturation over a 300-word message.
      for (int i = 0; i < 300; i++) begin
         send(1, 16'(i * 7 + 3), 1'(i == 299), 1'b1, 1'b0, 8'd0, w);
      end
      drain();
      wait_bits(4);
      check("sat_msg", 32'(msg_of(1)), 32'd255);
      send(1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 8'd0, w);
      drain();
      wait_bits(4);
      check("after_sat_msg", 32'(msg_of(1)), 32'd1);

      check("send_timeouts", 32'(timeouts), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
